image_stream_loader: RTL and testbench

- Writer-side counterpart to the image ROM that feeds Layer 1.
- Accepts an 8-bit pixel stream over a valid/ready handshake and quantizes each pixel to 4 bits.
- Writes pixels into an internal 784-entry image buffer. The global controller reads the buffer through a ROM-compatible port.
- Pulses the network start once a complete, correctly framed image is loaded. Locks the buffer until the network reports completion.

---
 rtl/image_stream_loader.sv | 168 ++++++++++++++++
 tb/tb_image_stream_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_loader.sv
// image_stream_loader
//
// Writer-side counterpart to the Layer 1 image ROM. Accepts an 8-bit pixel
// stream and keeps the upper PIX_W bits of each pixel in a NUM_PIXELS-deep
// buffer. The global controller reads the buffer through a ROM-compatible
// port. When a complete, correctly framed image has been loaded, the block
// pulses start_out. It then locks the buffer until net_done.
//
// Handshake: a pixel transfers on a rising edge where s_valid=1 and
// s_ready=1. s_ready depends only on registered state, never on s_valid.
// s_data and s_last are ignored while s_valid=0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   s_valid    input pixel valid
//   s_data     input pixel value (IN_W bits)
//   s_last     final pixel of a frame
//   s_ready    loader accepts a pixel this cycle
//   rd_addr    read address from the controller address bus
//   rd_q       registered read data (1-cycle latency, 0 when out of range)
//   net_done   one-cycle pulse: network finished classification
//   start_out  one-cycle pulse to the controller start input
//   frame_err  sticky framing error, cleared by the next good frame
//   frame_cnt  frames successfully loaded, wraps 255->0
//   dbg_state  current FSM state (LOAD=0, DRAIN=1, START=2, RUN=3)

module image_stream_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10,
  parameter int IN_W       = 8,
  parameter int PIX_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_q,
  input  logic              net_done,
  output logic              start_out,
  output logic              frame_err,
  output logic [7:0]        frame_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(NUM_PIXELS);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   wr_ptr_nxt;
  logic                err_nxt;
  logic [7:0]          cnt_nxt;
  logic                wr_en;
  logic                accept;
  // Held low by reset so s_ready stays low until the first edge after
  // rst deasserts, even though the FSM already sits in LOAD.
  logic                armed;

  logic [PIX_W-1:0]    mem [NUM_PIXELS];

  assign dbg_state = state;

  // Next-state and output logic
  always_comb begin
    next_state = state;
    wr_ptr_nxt = wr_ptr;
    err_nxt    = frame_err;
    cnt_nxt    = frame_cnt;
    wr_en      = 1'b0;
    s_ready    = 1'b0;
    start_out  = 1'b0;
    accept     = 1'b0;

    case (state)
      ST_LOAD: begin
        s_ready = armed;
        accept  = s_valid && armed;
        if (accept) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_ADDR) begin
            wr_ptr_nxt = '0;
            if (s_last) begin
              next_state = ST_START;
            end else begin
              // Frame runs past the buffer: discard the rest up to s_last.
              next_state = ST_DRAIN;
              err_nxt    = 1'b1;
            end
          end else if (s_last) begin
            // Short frame: flag it and restart at address 0.
            err_nxt    = 1'b1;
            wr_ptr_nxt = '0;
          end else begin
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        s_ready = armed;
        accept  = s_valid && armed;
        if (accept && s_last) begin
          next_state = ST_LOAD;
          wr_ptr_nxt = '0;
        end
      end

      ST_START: begin
        start_out  = 1'b1;
        err_nxt    = 1'b0;
        cnt_nxt    = frame_cnt + 8'd1;
        next_state = ST_RUN;
      end

      ST_RUN: begin
        if (net_done) begin
          next_state = ST_LOAD;
        end
      end

      default: begin
        next_state = ST_LOAD;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_LOAD;
      wr_ptr    <= '0;
      frame_err <= 1'b0;
      frame_cnt <= 8'd0;
      armed     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state     <= next_state;
      wr_ptr    <= wr_ptr_nxt;
      frame_err <= err_nxt;
      frame_cnt <= cnt_nxt;
      armed     <= 1'b1;
      // Read-before-write: the non-blocking write below lands after this
      // read samples the old word.
      rd_q      <= (rd_addr < DEPTH) ? mem[rd_addr] : '0;
    end
  end

  // Image buffer. Not reset; writes only happen in LOAD, so the image is
  // frozen through START and RUN.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_data[IN_W-1 -: PIX_W];
    end
  end

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed testbench for image_stream_loader.
module tb_image_stream_loader;

  localparam int NUM_PIXELS = 784;

  // Clock
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic [9:0] rd_addr;
  logic [3:0] rd_q;
  logic       net_done;
  logic       start_out;
  logic       frame_err;
  logic [7:0] frame_cnt;
  logic [1:0] dbg_state;

  image_stream_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .rd_addr   (rd_addr),
    .rd_q      (rd_q),
    .net_done  (net_done),
    .start_out (start_out),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int start_count = 0;

  logic [3:0] exp_mem [NUM_PIXELS];
  logic [3:0] exp_q [$];

  typedef struct {
    logic [9:0] addr;
    logic [3:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [8];

  // Count every cycle in which start_out is high.
  always @(negedge clk) begin
    if (start_out === 1'b1) start_count++;
  end

  // Global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pix(input int seed, input int i);
    if (i == 0) return 8'hA7;
    if (i == NUM_PIXELS - 1) return 8'h3F;
    return 8'((i * 13 + seed) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input int a);
    exp_q.push_back(exp_mem[a]);
    rd_addr = 10'(a);
    @(posedge clk); #1;
    check($sformatf("mem[%0d]", a), 32'(rd_q), 32'(exp_q.pop_front()));
  endtask

  task automatic finish_run();
    net_done = 1'b1;
    @(posedge clk); #1;
    net_done = 1'b0;
    check("ready_after_done", 32'(s_ready), 32'd1);
  endtask

  // Streams n pixels (index 0..n-1), s_last on last_idx. rbw_idx selects a
  // pixel whose address is also read in its accept cycle.
  task automatic send_frame(input int n, input int last_idx, input int seed,
                            input bit gaps, input int rbw_idx);
    logic [7:0] p;
    logic [3:0] old;
    int wait_cyc;
    old = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 0) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      p       = pix(seed, i);
      s_valid = 1'b1;
      s_data  = p;
      s_last  = (i == last_idx);
      if (i == rbw_idx) begin
        rd_addr = 10'(i);
        old     = exp_mem[i];
      end
      wait_cyc = 0;
      while (s_ready !== 1'b1) begin
        @(posedge clk); #1;
        wait_cyc++;
        if (wait_cyc > 100) begin
          check("accept_timeout", 32'd0, 32'd1);
          s_valid = 1'b0;
          s_last  = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      if (i < NUM_PIXELS) exp_mem[i] = p[7:4];
      if (i == rbw_idx) check("read_before_write", 32'(rd_q), 32'(old));
      if (i == NUM_PIXELS - 1 && n > NUM_PIXELS) begin
        check("long_err_after_783", 32'(frame_err), 32'd1);
        check("long_state_drain", 32'(dbg_state), 32'd1);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{addr: 10'd0,    exp: 4'hA};
    tbl[1] = '{addr: 10'd783,  exp: 4'h3};
    tbl[2] = '{addr: 10'd10,   exp: 4'h8};
    tbl[3] = '{addr: 10'd100,  exp: 4'h1};
    tbl[4] = '{addr: 10'd500,  exp: 4'h6};
    tbl[5] = '{addr: 10'd255,  exp: 4'hF};
    tbl[6] = '{addr: 10'd784,  exp: 4'h0};
    tbl[7] = '{addr: 10'd1000, exp: 4'h0};

    rst      = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'd0;
    s_last   = 1'b0;
    net_done = 1'b0;
    rd_addr  = 10'd0;

    // Reset state
    #2;
    check("rst_ready",     32'(s_ready),   32'd0);
    check("rst_start",     32'(start_out), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_rd_q",      32'(rd_q),      32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    check("ready_before_first_edge", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_first_edge", 32'(s_ready), 32'd1);

    // Gap-free frame A
    send_frame(784, 783, 0, 1'b0, -1);
    check("a_start_pulse", 32'(start_out), 32'd1);
    check("a_ready_in_start", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("a_start_width", 32'(start_out), 32'd0);
    check("a_frame_cnt", 32'(frame_cnt), 32'd1);
    check("a_frame_err", 32'(frame_err), 32'd0);
    check("a_state_run", 32'(dbg_state), 32'd3);
    check("a_start_count", 32'(start_count), 32'd1);
    for (int k = 0; k < 8; k++) begin
      rd_addr = tbl[k].addr;
      @(posedge clk); #1;
      check($sformatf("rd_table[%0d]", k), 32'(rd_q), 32'(tbl[k].exp));
    end

    // Buffer lock in RUN: stream pushes but nothing is taken
    s_valid = 1'b1;
    s_data  = 8'hFF;
    s_last  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      check("run_ready_low", 32'(s_ready), 32'd0);
    end
    for (int k = 0; k < 10; k++) check_mem(k * 87);
    net_done = 1'b1;
    @(posedge clk); #1;
    net_done = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    check("ready_after_done", 32'(s_ready), 32'd1);
    check("run_no_extra_start", 32'(start_count), 32'd1);

    // Short frame, then a good frame
    send_frame(100, 99, 50, 1'b0, -1);
    check("short_no_start", 32'(start_out), 32'd0);
    check("short_err", 32'(frame_err), 32'd1);
    check("short_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    check("short_start_count", 32'(start_count), 32'd1);
    check("short_frame_cnt", 32'(frame_cnt), 32'd1);
    check_mem(1);
    check_mem(99);
    check_mem(100);
    send_frame(784, 783, 3, 1'b0, -1);
    check("good_start_pulse", 32'(start_out), 32'd1);
    @(posedge clk); #1;
    check("good_err_cleared", 32'(frame_err), 32'd0);
    check("good_frame_cnt", 32'(frame_cnt), 32'd2);
    check("good_start_count", 32'(start_count), 32'd2);
    finish_run();

    // Long frame: 790 pixels, s_last on 789
    send_frame(790, 789, 9, 1'b0, -1);
    check("long_no_start", 32'(start_out), 32'd0);
    check("long_err", 32'(frame_err), 32'd1);
    check("long_state_load", 32'(dbg_state), 32'd0);
    check("long_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    check("long_start_count", 32'(start_count), 32'd2);
    for (int k = 0; k < 6; k++) check_mem(k);
    check_mem(783);

    // Frame A again with random valid gaps
    send_frame(784, 783, 0, 1'b1, -1);
    check("gap_start_pulse", 32'(start_out), 32'd1);
    @(posedge clk); #1;
    check("gap_start_count", 32'(start_count), 32'd3);
    check("gap_err_cleared", 32'(frame_err), 32'd0);
    check("gap_frame_cnt", 32'(frame_cnt), 32'd3);
    for (int a = 0; a < NUM_PIXELS; a++) check_mem(a);
    check("gap_single_start", 32'(start_count), 32'd3);
    finish_run();

    // Reset in the middle of a frame
    send_frame(400, -1, 7, 1'b0, -1);
    s_valid = 1'b1;
    s_data  = pix(7, 400);
    rd_addr = 10'd3;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(s_ready),   32'd0);
    check("mid_rst_start", 32'(start_out), 32'd0);
    check("mid_rst_err",   32'(frame_err), 32'd0);
    check("mid_rst_cnt",   32'(frame_cnt), 32'd0);
    check("mid_rst_rd_q",  32'(rd_q),      32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_back", 32'(s_ready), 32'd1);
    send_frame(784, 783, 200, 1'b0, 5);
    check("post_rst_start", 32'(start_out), 32'd1);
    @(posedge clk); #1;
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    check("post_rst_start_count", 32'(start_count), 32'd4);
    rd_addr = 10'd1000;
    @(posedge clk); #1;
    check("rd_1000", 32'(rd_q), 32'd0);
    rd_addr = 10'd784;
    @(posedge clk); #1;
    check("rd_784", 32'(rd_q), 32'd0);
    check_mem(0);
    check_mem(5);
    check_mem(399);
    check_mem(400);
    check_mem(783);
    finish_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
